// File: rtl/dot_product_pkg.sv
// Shared constants and FSM state encoding for the dot-product pipeline stages.
package dot_product_pkg;

    localparam int COMP_W     = 10;
    localparam int MAG_IN_W   = 9;
    localparam int PROD_W     = 19;
    localparam int PROD_MAG_W = 18;
    localparam int ITER_LAST  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sm_seq_multiplier.sv
// One sign-magnitude lane: sequential shift-add multiplier with sign and zero fixup.
module sm_seq_multiplier
    import dot_product_pkg::*;
#(
    parameter int DATA_W = MAG_IN_W,
    parameter int COEF_W = MAG_IN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     step,
    input  logic                     finish,
    input  logic [DATA_W:0]          a_in,
    input  logic [COEF_W:0]          b_in,
    output logic [DATA_W+COEF_W:0]   prod,
    output logic                     mplr_zero
);

    localparam int ACC_W = DATA_W + COEF_W;

    logic [ACC_W-1:0]  mcand_p0;
    logic [ACC_W-1:0]  acc_p0;
    logic [COEF_W-1:0] mplr_p0;
    logic              sign_p0;
    logic [ACC_W:0]    prod_p1;

    logic [ACC_W-1:0]  acc_sum;
    logic [COEF_W-1:0] mplr_shift;

    // Sign is dropped for a zero magnitude so no negative zero ever leaves the lane.
    function automatic logic [ACC_W:0] pack_sm(input logic s, input logic [ACC_W-1:0] m);
        return {s & (|m), m};
    endfunction

    assign acc_sum    = acc_p0 + (mplr_p0[0] ? mcand_p0 : '0);
    assign mplr_shift = mplr_p0 >> 1;
    assign mplr_zero  = (mplr_shift == '0);
    assign prod       = prod_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_p0 <= '0;
            acc_p0   <= '0;
            mplr_p0  <= '0;
            sign_p0  <= 1'b0;
            prod_p1  <= '0;
        end else begin
            if (load) begin
                mcand_p0 <= {{COEF_W{1'b0}}, a_in[DATA_W-1:0]};
                mplr_p0  <= b_in[COEF_W-1:0];
                acc_p0   <= '0;
                sign_p0  <= a_in[DATA_W] ^ b_in[COEF_W];
            end else if (step) begin
                acc_p0   <= acc_sum;
                mplr_p0  <= mplr_shift;
                mcand_p0 <= mcand_p0 << 1;
            end
            // ---- output stage: result captured on the last MUL edge, held through DONE
            if (finish) begin
                prod_p1 <= pack_sm(sign_p0, acc_sum);
            end
        end
    end

endmodule

// File: rtl/dot_product_stage_1.sv
// Three-lane sign-magnitude multiplier stage with IDLE/MUL/DONE handshake FSM.
// Optional macro DOT_STAGE1_EARLY_EXIT_EN ends MUL once every multiplier has shifted to zero.
module dot_product_stage_1
    import dot_product_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3*COMP_W-1:0] stage1_vec_a,
    input  logic [3*COMP_W-1:0] stage1_vec_b,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PROD_W-1:0]   stage1_out_1,
    output logic [PROD_W-1:0]   stage1_out_2,
    output logic [PROD_W-1:0]   stage1_out_3,
    output logic                out_valid,
    input  logic                out_ready
);

`ifdef DOT_STAGE1_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_t     state;
    logic [3:0] iter_cnt;
    logic       load;
    logic       step;
    logic       last_iter;
    logic       finish;
    logic [2:0] zero_lane;

    assign load      = (state == ST_IDLE) && in_valid;
    assign step      = (state == ST_MUL);
    assign last_iter = (iter_cnt == 4'(ITER_LAST)) || (EARLY_EXIT && (&zero_lane));
    assign finish    = step && last_iter;

    sm_seq_multiplier u_lane_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .a_in      (stage1_vec_a[3*COMP_W-1:2*COMP_W]),
        .b_in      (stage1_vec_b[3*COMP_W-1:2*COMP_W]),
        .prod      (stage1_out_1),
        .mplr_zero (zero_lane[0])
    );

    sm_seq_multiplier u_lane_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .a_in      (stage1_vec_a[2*COMP_W-1:COMP_W]),
        .b_in      (stage1_vec_b[2*COMP_W-1:COMP_W]),
        .prod      (stage1_out_2),
        .mplr_zero (zero_lane[1])
    );

    sm_seq_multiplier u_lane_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .a_in      (stage1_vec_a[COMP_W-1:0]),
        .b_in      (stage1_vec_b[COMP_W-1:0]),
        .prod      (stage1_out_3),
        .mplr_zero (zero_lane[2])
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            iter_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_MUL;
                        iter_cnt <= '0;
                        in_ready <= 1'b0;
                    end
                end
                ST_MUL: begin
                    iter_cnt <= iter_cnt + 4'd1;
                    if (last_iter) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dot_product_stage_1.md
DOT_PRODUCT_STAGE_1 -- requirements
Module: dot_product_stage_1

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: reset is sampled only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 stage1_vec_a  input  30  vector A as {x,y,z}; each component is 10-bit sign-magnitude (bit 9 sign, bits 8:0 magnitude).
REQ-005 stage1_vec_b  input  30  vector B, same packing as stage1_vec_a.
REQ-006 in_valid  input  1  vector pair is presented.
REQ-007 in_ready  output  1  block can accept a vector pair.
REQ-008 stage1_out_1 / stage1_out_2 / stage1_out_3  output  19 each  x/y/z products as sign-magnitude (bit 18 sign, bits 17:0 magnitude); these feed dot_product_stage_2 inputs 1/2/3.
REQ-009 out_valid  output  1  products are valid.
REQ-010 out_ready  input  1  downstream accepts the products.

Function
REQ-011 The FSM SHALL have three states: IDLE, MUL and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-012 On a rising edge with IDLE and in_valid=1, the block SHALL capture the operands, clear the three 18-bit accumulators, clear the 4-bit iteration counter and enter MUL.
REQ-013 Each MUL edge SHALL, per lane, add the left-shifted multiplicand to the accumulator when multiplier bit 0 is 1, then shift the multiplier right by 1, shift the multiplicand left by 1 and increment the counter.
REQ-014 MUL SHALL go to DONE on the edge that performs iteration 9 (counter=8), so out_valid rises 9 cycles after the accept edge.
REQ-015 Each product magnitude SHALL be the exact 9x9 product in 18 bits, with no saturation.
REQ-016 Each product sign SHALL be sign_a XOR sign_b, forced to 0 when the product magnitude is 0 (no negative zero).
REQ-017 The outputs SHALL be registered and held stable throughout DONE.
REQ-018 DONE with out_ready=1 SHALL go to IDLE on that edge; DONE with out_ready=0 SHALL hold indefinitely.
REQ-019 in_valid SHALL be ignored outside IDLE, and operands presented while busy SHALL NOT be captured.
REQ-020 Throughput SHALL be at most one vector pair per 11 cycles: 1 IDLE + 9 MUL + 1 DONE.

Reset
REQ-021 With rst_n=0 at an edge, the state SHALL go to IDLE and all accumulators, counters and stage1_out_1/2/3 SHALL be set to 0; this makes out_valid=0 and in_ready=1 after that edge.
REQ-022 Reset in MUL or DONE SHALL abort the operation, and the partial result SHALL NOT be presented.

Configuration
REQ-023 With DOT_STAGE1_EARLY_EXIT_EN defined, MUL SHALL also go to DONE on any edge after which all three shifted multipliers are 0. The minimum is 1 MUL cycle, so all-zero B gives out_valid 1 cycle after accept.
REQ-024 Without DOT_STAGE1_EARLY_EXIT_EN, latency SHALL be fixed at 9 cycles regardless of operand values.
REQ-025 In both builds the products SHALL be identical; only latency differs.

Structure
REQ-026 Package dot_product_pkg SHALL hold COMP_W=10, MAG_IN_W=9, PROD_W=19, PROD_MAG_W=18, ITER_LAST=8 and the FSM state enumeration; dot_product_stage_2 shares the PROD_W constants.
REQ-027 One sub-module, sm_seq_multiplier, SHALL implement a single lane (registers, shift-add, sign and zero fixup) and SHALL be instantiated three times. The FSM and counter SHALL live in the top level.

Verification
REQ-028 A=(+3,+5,+7), B=(+2,-4,+6) -> out_valid rises 9 cycles after accept; outputs are {0,6}, {1,20}, {0,42}.
REQ-029 A=(-511,-511,+511), B=(-511,+511,+511) -> each magnitude is 261121 (0x3FC01); signs are 0, 1, 0.
REQ-030 A=(-5,+0,+9), B=(+0,-7,-0) -> all magnitudes are 0 and all signs are 0.
REQ-031 Hold out_ready=0 for 20 cycles in DONE while toggling in_valid and the operands -> outputs are stable and in_ready=0; raising out_ready gives IDLE on the next edge.
REQ-032 Assert rst_n=0 for one edge at MUL iteration 4 -> out_valid never rises and outputs=0; a new pair accepted next gives the correct products.
REQ-033 With DOT_STAGE1_EARLY_EXIT_EN defined: B=(+1,+2,+3) -> out_valid 2 cycles after accept; B=0 -> 1 cycle; without the macro both cases take 9 cycles.
